w_full_ctrl: RTL

Write-side pointer and full-flag controller for the asynchronous FIFO, running entirely in the write clock domain. It synchronises the read pointer (Gray, from the read-side empty logic) into the write domain and advances the write pointer on accepted writes. It produces the registered full, almost-full and fill-level indications, plus the RAM write address and strobe. It is the write-side counterpart of the read-side empty checker: it produces `w_ptr_gray` for that block and consumes its `r_ptr_gray`.

---
 rtl/asyn_fifo_pkg.sv | 38 +++
 rtl/ptr_sync.sv | 30 +++
 rtl/w_full_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/asyn_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer logic.
// Provides the binary/Gray conversion helpers used by both clock domains,
// plus the default geometry constants (depth and pointer width).
package asyn_fifo_pkg;

  localparam int ADDR_SIZE_DEF = 4;
  localparam int DEPTH         = 1 << ADDR_SIZE_DEF;
  localparam int PTR_W         = ADDR_SIZE_DEF + 1;

  // Pointer width for an arbitrary address size: one extra MSB separates
  // the full and empty cases when the low bits match.
  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

  // Binary to Gray. Bits at or above w are masked to zero.
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (b ^ (b >> 1)) & mask;
  endfunction

  // Gray to binary. Each binary bit is the XOR of all Gray bits at or
  // above it; bits at or above w are masked to zero first.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] mask;
    logic [31:0] gm;
    logic [31:0] b;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    gm   = g & mask;
    b    = gm;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Ports:
//   clk  - destination-domain clock, rising edge
//   rst  - synchronous, active-low reset; clears every stage
//   d    - Gray pointer from the other domain (asynchronous)
//   q    - synchronised pointer (last stage)
module ptr_sync #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/w_full_ctrl.sv
// Write-side pointer and full-flag controller of the asynchronous FIFO.
// Runs entirely in the write clock domain: synchronises the read Gray
// pointer, advances the write pointer on accepted writes and produces
// registered full / almost-full / level flags plus the RAM write port.
// Ports:
//   w_clk, w_rst   - write clock, synchronous active-low reset
//   w_en           - write request
//   r_ptr_gray     - read pointer (Gray) from the read domain
//   w_ovf_clr      - clears the sticky overflow flag
//   w_full         - registered full flag
//   w_almost_full  - registered level >= AFULL_THRESH
//   w_level        - registered, pessimistic fill level (0..DEPTH)
//   w_addr         - RAM write address
//   w_mem_en       - RAM write strobe (combinational)
//   w_ptr_gray     - registered write pointer (Gray) for the read domain
//   w_overflow     - sticky: write attempted while full
module w_full_ctrl
  import asyn_fifo_pkg::*;
#(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 12,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_en,
  input  logic [ADDR_SIZE:0]   r_ptr_gray,
  input  logic                 w_ovf_clr,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic [ADDR_SIZE:0]   w_level,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic                 w_mem_en,
  output logic [ADDR_SIZE:0]   w_ptr_gray,
  output logic                 w_overflow
);

  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] rq;
  logic [PW-1:0] r_bin;
  logic [PW-1:0] w_ptr_bin;
  logic [PW-1:0] w_ptr_bin_next;
  logic [PW-1:0] w_ptr_gray_next;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_target;
  logic          w_inc;

  ptr_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (w_clk),
    .rst (w_rst),
    .d   (r_ptr_gray),
    .q   (rq)
  );

  assign w_inc           = w_en & ~w_full;
  assign w_mem_en        = w_inc & w_rst;
  assign w_addr          = w_ptr_bin[ADDR_SIZE-1:0];
  assign w_ptr_bin_next  = w_ptr_bin + {{(PW-1){1'b0}}, w_inc};
  assign w_ptr_gray_next = PW'(bin2gray(32'(w_ptr_bin_next), PW));
  assign r_bin           = PW'(gray2bin(32'(rq), PW));
  assign level_next      = w_ptr_bin_next - r_bin;

  // Full when the write pointer is exactly one lap ahead of the
  // synchronised read pointer: in Gray code that is the top two bits
  // inverted and the rest equal.
  assign full_target = {~rq[ADDR_SIZE:ADDR_SIZE-1], rq[ADDR_SIZE-2:0]};

  // Pointer, flag and level registers all update on the accepting edge
  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      w_ptr_bin     <= '0;
      w_ptr_gray    <= '0;
      w_full        <= 1'b0;
      w_almost_full <= 1'b0;
      w_level       <= '0;
      w_overflow    <= 1'b0;
    end else begin
      w_ptr_bin     <= w_ptr_bin_next;
      w_ptr_gray    <= w_ptr_gray_next;
      w_full        <= (w_ptr_gray_next == full_target);
      w_almost_full <= (level_next >= PW'(AFULL_THRESH));
      w_level       <= level_next;
      // A blocked write in the same cycle as a clear keeps the flag set.
      if (w_en && w_full) w_overflow <= 1'b1;
      else if (w_ovf_clr) w_overflow <= 1'b0;
    end
  end

endmodule
